// File: rtl/lc3_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_pkg
// Description : Shared definitions for the LC-3 memory controller: device
//               register addresses, FSM state encoding, keyboard interrupt
//               vector and priority.
// Revision    : 1.0 - initial release
// ============================================================================
package lc3_mem_pkg;

    // Memory-mapped device addresses
    localparam logic [15:0] c_mmio_base = 16'hFE00;
    localparam logic [15:0] c_kbsr_addr = 16'hFE00;
    localparam logic [15:0] c_kbdr_addr = 16'hFE02;
    localparam logic [15:0] c_dsr_addr  = 16'hFE04;
    localparam logic [15:0] c_ddr_addr  = 16'hFE06;
    localparam logic [15:0] c_mcr_addr  = 16'hFFFE;

    // Machine control register comes out of reset with the clock enabled
    localparam logic [15:0] c_mcr_reset = 16'h8000;

    // Keyboard interrupt vector and priority
    localparam logic [7:0]  c_kbd_intv  = 8'h80;
    localparam logic [2:0]  c_kbd_intp  = 3'd4;

    // Request FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } mem_state_t;

endpackage : lc3_mem_pkg
`default_nettype wire

// File: rtl/lc3_mmio_regs.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mmio_regs
// Description : LC-3 memory-mapped device registers: keyboard (KBSR/KBDR),
//               display (DSR/DDR) with valid/ready handshake, machine control
//               register, and optional keyboard interrupt generation.
//               Optional feature macro: LC3_MEM_KBD_IRQ_EN
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mmio_regs
    import lc3_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    // Access strobes, asserted on the edge that completes a request
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_wdata,
    output logic [15:0] o_rdata,
    // Keyboard
    input  logic        i_kbd_valid,
    input  logic [7:0]  i_kbd_data,
    // Display
    output logic        o_disp_valid,
    output logic [7:0]  o_disp_data,
    input  logic        i_disp_ready,
    // Machine control and interrupt
    output logic [15:0] o_mcr,
    output logic        o_irq,
    output logic [7:0]  o_intv,
    output logic [2:0]  o_intp
);

    logic       r_kbsr_rdy;
    logic [7:0] r_kbdr;
    logic       w_kbsr_ie;
    logic       w_kbdr_rd;
    logic       w_kbd_accept;

    assign w_kbdr_rd    = i_rd && (i_addr == c_kbdr_addr);
    // A character is taken when the buffer is empty or being emptied right now
    assign w_kbd_accept = i_kbd_valid && (!r_kbsr_rdy || w_kbdr_rd);

    // Keyboard data buffer and ready flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kbsr_rdy <= 1'b0;
            r_kbdr     <= 8'h00;
        end else if (w_kbd_accept) begin
            r_kbsr_rdy <= 1'b1;
            r_kbdr     <= i_kbd_data;
        end else if (w_kbdr_rd) begin
            r_kbsr_rdy <= 1'b0;
        end
    end

    // Display handshake: completion has priority, writes while busy are dropped
    always_ff @(posedge clk) begin
        if (rst) begin
            o_disp_valid <= 1'b0;
            o_disp_data  <= 8'h00;
        end else if (o_disp_valid && i_disp_ready) begin
            o_disp_valid <= 1'b0;
        end else if (i_wr && (i_addr == c_ddr_addr) && !o_disp_valid) begin
            o_disp_valid <= 1'b1;
            o_disp_data  <= i_wdata[7:0];
        end
    end

    // Machine control register
    always_ff @(posedge clk) begin
        if (rst) begin
            o_mcr <= c_mcr_reset;
        end else if (i_wr && (i_addr == c_mcr_addr)) begin
            o_mcr <= i_wdata;
        end
    end

`ifdef LC3_MEM_KBD_IRQ_EN
    logic r_kbsr_ie;

    assign w_kbsr_ie = r_kbsr_ie;

    // Keyboard interrupt enable bit
    always_ff @(posedge clk) begin
        if (rst) begin
            r_kbsr_ie <= 1'b0;
        end else if (i_wr && (i_addr == c_kbsr_addr)) begin
            r_kbsr_ie <= i_wdata[14];
        end
    end

    // Registered interrupt request with vector/priority valid alongside it
    always_ff @(posedge clk) begin
        if (rst) begin
            o_irq  <= 1'b0;
            o_intv <= 8'h00;
            o_intp <= 3'd0;
        end else begin
            o_irq  <= r_kbsr_rdy & r_kbsr_ie;
            o_intv <= (r_kbsr_rdy & r_kbsr_ie) ? c_kbd_intv : 8'h00;
            o_intp <= (r_kbsr_rdy & r_kbsr_ie) ? c_kbd_intp : 3'd0;
        end
    end
`else
    // Interrupts are compiled out: enable bit reads 0, outputs idle
    assign w_kbsr_ie = 1'b0;
    assign o_irq     = 1'b0;
    assign o_intv    = 8'h00;
    assign o_intp    = 3'd0;
`endif

    // Register read mux; unlisted device addresses read 0
    always_comb begin
        o_rdata = 16'h0000;
        case (i_addr)
            c_kbsr_addr: o_rdata = {r_kbsr_rdy, w_kbsr_ie, 14'h0000};
            c_kbdr_addr: o_rdata = {8'h00, r_kbdr};
            c_dsr_addr:  o_rdata = {!o_disp_valid, 15'h0000};
            c_mcr_addr:  o_rdata = o_mcr;
            default:     o_rdata = 16'h0000;
        endcase
    end

endmodule : lc3_mmio_regs
`default_nettype wire

// File: rtl/lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lc3_mem_ctrl
// Description : LC-3 memory controller. Accepts one CPU request at a time,
//               inserts WAIT_CYCLES wait states, then completes it with a
//               one-cycle memRDY pulse. Decodes RAM and the device page at
//               0xFE00-0xFFFF (handled by lc3_mmio_regs).
//               Optional feature macro: LC3_MEM_KBD_IRQ_EN
// Revision    : 1.0 - initial release
// ============================================================================
module lc3_mem_ctrl
    import lc3_mem_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int RAM_AW      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] memory_addr,
    input  logic [15:0] memory_din,
    input  logic        memWE,
    input  logic        memEN,
    output logic [15:0] memory_dout,
    output logic        memRDY,
    output logic [15:0] MCR,
    input  logic        kbd_valid,
    input  logic [7:0]  kbd_data,
    output logic        disp_valid,
    output logic [7:0]  disp_data,
    input  logic        disp_ready,
    output logic        IRQ,
    output logic [7:0]  INTV,
    output logic [2:0]  INTP
);

    // RAM never overlaps the device page
    localparam int c_ram_depth = ((2 ** RAM_AW) < 32'hFE00) ? (2 ** RAM_AW) : 32'hFE00;

    mem_state_t  r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_addr;
    logic [15:0] r_din;
    logic        r_we;

    logic [15:0] r_ram [0:c_ram_depth-1];

    logic        w_ram_hit;
    logic        w_mmio_sel;
    logic        w_commit;
    logic [15:0] w_ram_rdata;
    logic [15:0] w_mmio_rdata;
    logic [15:0] w_rdata;

    assign w_ram_hit    = (32'(r_addr) < 32'(c_ram_depth));
    assign w_mmio_sel   = (r_addr >= c_mmio_base);
    assign w_commit     = (r_state == ST_RESP);
    assign w_ram_rdata  = w_ram_hit ? r_ram[r_addr[RAM_AW-1:0]] : 16'h0000;
    assign w_rdata      = w_mmio_sel ? w_mmio_rdata : w_ram_rdata;

    // Request FSM with registered completion pulse and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 16'h0000;
            r_din       <= 16'h0000;
            r_we        <= 1'b0;
            memRDY      <= 1'b0;
            memory_dout <= 16'h0000;
        end else begin
            memRDY      <= 1'b0;
            memory_dout <= 16'h0000;
            case (r_state)
                ST_IDLE: begin
                    if (memEN) begin
                        r_addr  <= memory_addr;
                        r_din   <= memory_din;
                        r_we    <= memWE;
                        r_cnt   <= 4'(WAIT_CYCLES);
                        r_state <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        r_state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    memRDY      <= 1'b1;
                    memory_dout <= r_we ? 16'h0000 : w_rdata;
                    r_state     <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // RAM write port; contents survive reset, an aborted request never commits
    always_ff @(posedge clk) begin
        if (!rst && w_commit && r_we && w_ram_hit) begin
            r_ram[r_addr[RAM_AW-1:0]] <= r_din;
        end
    end

    lc3_mmio_regs u_mmio (
        .clk          (clk),
        .rst          (rst),
        .i_rd         (w_commit && !r_we && w_mmio_sel),
        .i_wr         (w_commit && r_we && w_mmio_sel),
        .i_addr       (r_addr),
        .i_wdata      (r_din),
        .o_rdata      (w_mmio_rdata),
        .i_kbd_valid  (kbd_valid),
        .i_kbd_data   (kbd_data),
        .o_disp_valid (disp_valid),
        .o_disp_data  (disp_data),
        .i_disp_ready (disp_ready),
        .o_mcr        (MCR),
        .o_irq        (IRQ),
        .o_intv       (INTV),
        .o_intp       (INTP)
    );

endmodule : lc3_mem_ctrl
`default_nettype wire

// File: tb/tb_lc3_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lc3_mem_ctrl
// Description : Scoreboard bench for lc3_mem_ctrl. Instance A uses two wait
//               states and a full RAM; instance B uses zero wait states and a
//               4K-word RAM. Expected responses (data and arrival cycle) are
//               queued at issue time and popped by per-instance monitors.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3_mem_ctrl;

    localparam int W_A = 2;
    localparam int W_B = 0;
`ifdef LC3_MEM_KBD_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] data;
        int          cyc;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    // Instance A signals
    logic [15:0] a_addr = '0, a_din = '0, a_dout, a_mcr;
    logic        a_we = 1'b0, a_en = 1'b0, a_rdy;
    logic        kbd_valid = 1'b0, disp_ready = 1'b0;
    logic [7:0]  kbd_data = '0;
    logic        disp_valid, irq;
    logic [7:0]  disp_data, intv;
    logic [2:0]  intp;

    // Instance B signals
    logic [15:0] b_addr = '0, b_din = '0, b_dout, b_mcr;
    logic        b_we = 1'b0, b_en = 1'b0, b_rdy;
    logic        b_kbd_valid = 1'b0, b_disp_ready = 1'b0;
    logic [7:0]  b_kbd_data = '0;
    logic        b_disp_valid, b_irq;
    logic [7:0]  b_disp_data, b_intv;
    logic [2:0]  b_intp;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lc3_mem_ctrl #(.WAIT_CYCLES(W_A), .RAM_AW(16)) dut_a (
        .clk(clk), .rst(rst), .memory_addr(a_addr), .memory_din(a_din),
        .memWE(a_we), .memEN(a_en), .memory_dout(a_dout), .memRDY(a_rdy),
        .MCR(a_mcr), .kbd_valid(kbd_valid), .kbd_data(kbd_data),
        .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready),
        .IRQ(irq), .INTV(intv), .INTP(intp)
    );

    lc3_mem_ctrl #(.WAIT_CYCLES(W_B), .RAM_AW(12)) dut_b (
        .clk(clk), .rst(rst), .memory_addr(b_addr), .memory_din(b_din),
        .memWE(b_we), .memEN(b_en), .memory_dout(b_dout), .memRDY(b_rdy),
        .MCR(b_mcr), .kbd_valid(b_kbd_valid), .kbd_data(b_kbd_data),
        .disp_valid(b_disp_valid), .disp_data(b_disp_data), .disp_ready(b_disp_ready),
        .IRQ(b_irq), .INTV(b_intv), .INTP(b_intp)
    );

    // Monitor A: every memRDY must match the oldest expected response
    always @(negedge clk) begin
        if (!rst && a_rdy) begin
            checks++;
            if (qa.size() == 0) begin
                failures++;
                $display("FAIL a_unexpected_rdy: got memRDY=1 at cycle %0d, required no response", cyc);
            end else begin
                ea = qa.pop_front();
                if (a_dout !== ea.data || cyc != ea.cyc) begin
                    failures++;
                    $display("FAIL %s: got data=0x%04h cycle=%0d, required data=0x%04h cycle=%0d",
                             ea.name, a_dout, cyc, ea.data, ea.cyc);
                end
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (!rst && b_rdy) begin
            checks++;
            if (qb.size() == 0) begin
                failures++;
                $display("FAIL b_unexpected_rdy: got memRDY=1 at cycle %0d, required no response", cyc);
            end else begin
                eb = qb.pop_front();
                if (b_dout !== eb.data || cyc != eb.cyc) begin
                    failures++;
                    $display("FAIL %s: got data=0x%04h cycle=%0d, required data=0x%04h cycle=%0d",
                             eb.name, b_dout, cyc, eb.data, eb.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%04h, required 0x%04h", name, act, exp);
        end
    endtask

    // Present a one-cycle request to A (called at a negedge); response due
    // 1+WAIT cycles after the accepting edge
    task automatic a_issue(input string nm, input logic [15:0] ad, input logic [15:0] d,
                           input logic we, input logic [15:0] exp, input bit push);
        exp_t e;
        a_addr = ad; a_din = d; a_we = we; a_en = 1'b1;
        if (push) begin
            e.data = exp; e.cyc = cyc + 2 + W_A; e.name = nm;
            qa.push_back(e);
        end
        @(negedge clk);
        a_en = 1'b0;
    endtask

    task automatic a_wait(input string nm);
        int n = 0;
        while (!a_rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!a_rdy) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no memRDY in 40 cycles, required memRDY", nm);
        end
        @(negedge clk);
    endtask

    task automatic a_op(input string nm, input logic [15:0] ad, input logic [15:0] d,
                        input logic we, input logic [15:0] exp);
        a_issue(nm, ad, d, we, exp, 1'b1);
        a_wait(nm);
    endtask

    task automatic b_op(input string nm, input logic [15:0] ad, input logic [15:0] d,
                        input logic we, input logic [15:0] exp);
        exp_t e;
        int n = 0;
        b_addr = ad; b_din = d; b_we = we; b_en = 1'b1;
        e.data = exp; e.cyc = cyc + 2 + W_B; e.name = nm;
        qb.push_back(e);
        @(negedge clk);
        b_en = 1'b0;
        while (!b_rdy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!b_rdy) begin
            checks++; failures++;
            $display("FAIL %s_timeout: got no memRDY in 40 cycles, required memRDY", nm);
        end
        @(negedge clk);
    endtask

    task automatic kbd(input logic [7:0] ch);
        kbd_data = ch; kbd_valid = 1'b1;
        @(negedge clk);
        kbd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   seen;
        exp_t e;
        int   c0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset values
        chk("rst_rdy",       {15'h0, a_rdy},     16'h0000);
        chk("rst_dout",      a_dout,             16'h0000);
        chk("rst_mcr",       a_mcr,              16'h8000);
        chk("rst_disp_vld",  {15'h0, disp_valid}, 16'h0000);
        chk("rst_disp_data", {8'h0, disp_data},  16'h0000);
        chk("rst_irq",       {15'h0, irq},       16'h0000);
        chk("rst_intv",      {8'h0, intv},       16'h0000);
        chk("rst_intp",      {13'h0, intp},      16'h0000);

        // RAM write/read with two wait states
        a_op("wr_3000",  16'h3000, 16'h1234, 1'b1, 16'h0000);
        a_op("rd_3000",  16'h3000, 16'h0000, 1'b0, 16'h1234);
        a_op("wr_3001",  16'h3001, 16'h0007, 1'b1, 16'h0000);
        a_op("wr_fdff",  16'hFDFF, 16'hA5A5, 1'b1, 16'h0000);
        a_op("rd_fdff",  16'hFDFF, 16'h0000, 1'b0, 16'hA5A5);
        a_op("rd_fe08",  16'hFE08, 16'h0000, 1'b0, 16'h0000);

        // MCR read/write
        a_op("wr_mcr",   16'hFFFE, 16'h1234, 1'b1, 16'h0000);
        chk("mcr_port",  a_mcr, 16'h1234);
        a_op("rd_mcr",   16'hFFFE, 16'h0000, 1'b0, 16'h1234);

        // Keyboard: second character while full is dropped
        kbd(8'h41);
        kbd(8'h42);
        a_op("rd_kbsr1", 16'hFE00, 16'h0000, 1'b0, 16'h8000);
        a_op("rd_kbdr1", 16'hFE02, 16'h0000, 1'b0, 16'h0041);
        a_op("rd_kbsr2", 16'hFE00, 16'h0000, 1'b0, 16'h0000);

        // Keyboard: character arriving on the KBDR read-clear edge is kept
        kbd(8'h43);
        a_issue("rd_kbdr_clr", 16'hFE02, 16'h0000, 1'b0, 16'h0043, 1'b1);
        repeat (2) @(negedge clk);
        kbd_data = 8'h44; kbd_valid = 1'b1;
        @(negedge clk);
        kbd_valid = 1'b0;
        a_wait("rd_kbdr_clr");
        a_op("rd_kbsr3", 16'hFE00, 16'h0000, 1'b0, 16'h8000);
        a_op("rd_kbdr3", 16'hFE02, 16'h0000, 1'b0, 16'h0044);

        // Interrupt enable and keyboard interrupt
        a_op("wr_kbsr",  16'hFE00, 16'h4000, 1'b1, 16'h0000);
        a_op("rd_kbsr4", 16'hFE00, 16'h0000, 1'b0, IRQ_EN ? 16'h4000 : 16'h0000);
        kbd(8'h61);
        @(negedge clk);
        chk("irq_set",   {15'h0, irq},  IRQ_EN ? 16'h0001 : 16'h0000);
        chk("intv_set",  {8'h0, intv},  IRQ_EN ? 16'h0080 : 16'h0000);
        chk("intp_set",  {13'h0, intp}, IRQ_EN ? 16'h0004 : 16'h0000);
        a_op("rd_kbdr4", 16'hFE02, 16'h0000, 1'b0, 16'h0061);
        chk("irq_clr",   {15'h0, irq},  16'h0000);
        chk("intv_clr",  {8'h0, intv},  16'h0000);

        // Display handshake
        a_op("wr_ddr1",  16'hFE06, 16'h0058, 1'b1, 16'h0000);
        chk("disp_vld1", {15'h0, disp_valid}, 16'h0001);
        chk("disp_dat1", {8'h0, disp_data},   16'h0058);
        a_op("rd_dsr1",  16'hFE04, 16'h0000, 1'b0, 16'h0000);
        a_op("wr_ddr2",  16'hFE06, 16'h0059, 1'b1, 16'h0000);
        chk("disp_dat2", {8'h0, disp_data},   16'h0058);
        disp_ready = 1'b1;
        @(negedge clk);
        disp_ready = 1'b0;
        chk("disp_vld2", {15'h0, disp_valid}, 16'h0000);
        a_op("rd_dsr2",  16'hFE04, 16'h0000, 1'b0, 16'h8000);

        // Reset during the wait states of a write aborts it
        a_issue("abort_wr", 16'h3001, 16'hDEAD, 1'b1, 16'h0000, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            seen |= a_rdy;
            @(negedge clk);
        end
        chk("abort_no_rdy", {15'h0, seen}, 16'h0000);
        chk("abort_mcr",    a_mcr, 16'h8000);
        a_op("rd_3001",  16'h3001, 16'h0000, 1'b0, 16'h0007);

        // Zero wait states: single op latency, then back-to-back reads
        b_op("b_wr_0100", 16'h0100, 16'hBEEF, 1'b1, 16'h0000);
        b_op("b_rd_0100", 16'h0100, 16'h0000, 1'b0, 16'hBEEF);
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            e.data = 16'hBEEF; e.cyc = c0 + 2 + 2 * k; e.name = $sformatf("b_b2b_%0d", k);
            qb.push_back(e);
        end
        b_addr = 16'h0100; b_we = 1'b0; b_en = 1'b1;
        repeat (5) @(negedge clk);
        b_en = 1'b0;
        repeat (4) @(negedge clk);

        // Unmapped RAM hole on the 4K-word instance
        b_op("b_wr_2000", 16'h2000, 16'h5555, 1'b1, 16'h0000);
        b_op("b_rd_2000", 16'h2000, 16'h0000, 1'b0, 16'h0000);

        repeat (4) @(negedge clk);
        chk("qa_drained", 16'(qa.size()), 16'h0000);
        chk("qb_drained", 16'(qb.size()), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_lc3_mem_ctrl
`default_nettype wire
